// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage_if
//  Purpose  : Bundles the fetch, regfile and ID/EX signals of the decode
//             stage. The master side is the decode stage itself; the slave
//             side is its surroundings (fetch, regfile, exec).
//  Revision : 1.0  initial release
// ============================================================================
interface decode_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  // fetch side
  logic [DATA_W-1:0] insn;
  logic              fetch_hold;
  // exec control
  logic              branch_flag;
  logic              ex_stall;
  // regfile read ports
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  // ID/EX bundle
  logic              ex_valid;
  logic [1:0]        ex_class;
  logic [3:0]        ex_funct;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_we;
  logic              ex_is_load;
  logic              ex_is_store;
  logic              ex_is_branch;
  logic [DATA_W-1:0] ex_rs1_val;
  logic [DATA_W-1:0] ex_rs2_val;
  logic [DATA_W-1:0] ex_imm;
  // status
  logic              illegal_insn;
  logic              halted;

  modport master (
    input  insn, branch_flag, ex_stall, rs1_data, rs2_data,
    output fetch_hold, rs1_addr, rs2_addr,
           ex_valid, ex_class, ex_funct, ex_rd, ex_we,
           ex_is_load, ex_is_store, ex_is_branch,
           ex_rs1_val, ex_rs2_val, ex_imm,
           illegal_insn, halted
  );

  modport slave (
    output insn, branch_flag, ex_stall, rs1_data, rs2_data,
    input  fetch_hold, rs1_addr, rs2_addr,
           ex_valid, ex_class, ex_funct, ex_rd, ex_we,
           ex_is_load, ex_is_store, ex_is_branch,
           ex_rs1_val, ex_rs2_val, ex_imm,
           illegal_insn, halted
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : Second pipeline stage of the 16-bit core. Splits the fetched
//             instruction into fields, sign-extends immediates, reads the
//             regfile and registers the ID/EX bundle. Interlocks one cycle
//             on load-use hazards, handles branch flush, exec back-pressure,
//             illegal opcodes and HALT.
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int HALT_EN = 1
) (
  input  wire logic           clk,
  input  wire logic           rst,
  decode_stage_if.master      bus
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_st_run    = 2'd0;  // normal decode
  localparam logic [1:0] c_st_haz    = 2'd1;  // one bubble already issued, held insn decodes now
  localparam logic [1:0] c_st_halted = 2'd2;  // absorbing until reset

  localparam logic [1:0] c_cls_alu = 2'b00;
  localparam logic [1:0] c_cls_br  = 2'b01;
  localparam logic [1:0] c_cls_mem = 2'b10;

  localparam logic [1:0] c_sub_li  = 2'b00;
  localparam logic [1:0] c_sub_ld  = 2'b01;
  localparam logic [1:0] c_sub_st  = 2'b10;

  localparam logic [REG_AW-1:0] c_link_reg = {REG_AW{1'b1}};

  // --------------------------------------------------------------------------
  // Registered state and ID/EX bundle
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic              r_ex_valid;
  logic [1:0]        r_ex_class;
  logic [3:0]        r_ex_funct;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_we;
  logic              r_ex_is_load;
  logic              r_ex_is_store;
  logic              r_ex_is_branch;
  logic [DATA_W-1:0] r_ex_rs1_val;
  logic [DATA_W-1:0] r_ex_rs2_val;
  logic [DATA_W-1:0] r_ex_imm;
  logic              r_illegal;

  // --------------------------------------------------------------------------
  // Combinational decode results
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_insn;
  logic [REG_AW-1:0] w_rs1_addr;
  logic [REG_AW-1:0] w_rs2_addr;
  logic [REG_AW-1:0] w_rd;
  logic              w_we;
  logic [3:0]        w_funct;
  logic [DATA_W-1:0] w_imm;
  logic              w_valid;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_branch;
  logic              w_illegal;
  logic              w_halt;
  logic [DATA_W-1:0] w_rs1_val;
  logic [DATA_W-1:0] w_rs2_val;
  logic              w_hazard;
  logic              w_accept;
  logic              w_fetch_hold;
  logic [1:0]        w_state_nxt;

  assign w_insn = bus.insn;

  // Field extraction and control decode; unused source fields stay at r0
  always_comb begin
    w_rs1_addr  = '0;
    w_rs2_addr  = '0;
    w_rd        = '0;
    w_we        = 1'b0;
    w_funct     = 4'd0;
    w_imm       = '0;
    w_valid     = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_illegal   = 1'b0;
    w_halt      = 1'b0;
    case (w_insn[15:14])
      c_cls_alu: begin
        // insn == 0 is the fetch bubble: every field decodes to zero
        w_funct    = w_insn[13:10];
        w_rd       = w_insn[9:7];
        w_rs1_addr = w_insn[6:4];
        w_rs2_addr = w_insn[3:1];
        w_we       = (w_insn[9:7] != '0);
        w_valid    = (w_insn != '0);
      end
      c_cls_br: begin
        w_funct     = {2'b00, w_insn[13:12]};
        w_rs1_addr  = w_insn[11:9];
        w_imm       = {{(DATA_W-9){w_insn[8]}}, w_insn[8:0]};
        w_is_branch = 1'b1;
        w_valid     = 1'b1;
        // cond 11 is branch-and-link into the top register
        if (w_insn[13:12] == 2'b11) begin
          w_rd = c_link_reg;
          w_we = 1'b1;
        end
      end
      c_cls_mem: begin
        w_funct = {2'b00, w_insn[13:12]};
        case (w_insn[13:12])
          c_sub_li: begin
            w_rd    = w_insn[11:9];
            w_we    = (w_insn[11:9] != '0);
            w_imm   = {{(DATA_W-9){w_insn[8]}}, w_insn[8:0]};
            w_valid = 1'b1;
          end
          c_sub_ld: begin
            w_rd       = w_insn[11:9];
            w_we       = (w_insn[11:9] != '0);
            w_rs1_addr = w_insn[8:6];
            w_imm      = {{(DATA_W-6){w_insn[5]}}, w_insn[5:0]};
            w_is_load  = 1'b1;
            w_valid    = 1'b1;
          end
          c_sub_st: begin
            w_rs2_addr = w_insn[11:9];
            w_rs1_addr = w_insn[8:6];
            w_imm      = {{(DATA_W-6){w_insn[5]}}, w_insn[5:0]};
            w_is_store = 1'b1;
            w_valid    = 1'b1;
          end
          default: begin
            w_funct   = 4'd0;
            w_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        // Class 11: only the all-zero payload is HALT; with HALT disabled it is a NOP
        if (w_insn[13:0] != 14'd0) begin
          w_illegal = 1'b1;
        end else if (HALT_EN != 0) begin
          w_halt = 1'b1;
        end
      end
    endcase
  end

  // r0 always reads as zero, whatever the regfile returns
  assign w_rs1_val = (w_rs1_addr == '0) ? '0 : bus.rs1_data;
  assign w_rs2_val = (w_rs2_addr == '0) ? '0 : bus.rs2_data;

  // Load-use hazard: a live load in ID/EX writes a register this insn reads.
  // Built only from insn-derived addresses and the registered bundle, so no
  // path exists from rs*_data into fetch_hold.
  assign w_hazard = r_ex_valid && r_ex_is_load &&
                    (((w_rs1_addr != '0) && (w_rs1_addr == r_ex_rd)) ||
                     ((w_rs2_addr != '0) && (w_rs2_addr == r_ex_rd)));

  // Current insn is consumed this cycle (may still decode to a bubble)
  assign w_accept = (r_state != c_st_halted) && !bus.ex_stall && !bus.branch_flag &&
                    !((r_state == c_st_run) && w_hazard);

  // Fetch repeats its insn when halted, stalled, or interlocking
  assign w_fetch_hold = (r_state == c_st_halted) || bus.ex_stall ||
                        (!bus.branch_flag && (r_state == c_st_run) && w_hazard);

  // Next-state selection in priority order: halted, stall, flush, hazard, decode
  always_comb begin
    w_state_nxt = c_st_run;
    if (r_state == c_st_halted) begin
      w_state_nxt = c_st_halted;
    end else if (bus.ex_stall) begin
      w_state_nxt = r_state;
    end else if (bus.branch_flag) begin
      w_state_nxt = c_st_run;
    end else if ((r_state == c_st_run) && w_hazard) begin
      w_state_nxt = c_st_haz;
    end else if (w_halt) begin
      w_state_nxt = c_st_halted;
    end
  end

  // ID/EX bundle register: hold on stall, issue on accept, otherwise a zero bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= c_st_run;
      r_ex_valid     <= 1'b0;
      r_ex_class     <= 2'd0;
      r_ex_funct     <= 4'd0;
      r_ex_rd        <= '0;
      r_ex_we        <= 1'b0;
      r_ex_is_load   <= 1'b0;
      r_ex_is_store  <= 1'b0;
      r_ex_is_branch <= 1'b0;
      r_ex_rs1_val   <= '0;
      r_ex_rs2_val   <= '0;
      r_ex_imm       <= '0;
      r_illegal      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_illegal <= w_accept && w_illegal;
      if ((r_state == c_st_halted) || !bus.ex_stall) begin
        if (w_accept && w_valid) begin
          r_ex_valid     <= 1'b1;
          r_ex_class     <= w_insn[15:14];
          r_ex_funct     <= w_funct;
          r_ex_rd        <= w_rd;
          r_ex_we        <= w_we;
          r_ex_is_load   <= w_is_load;
          r_ex_is_store  <= w_is_store;
          r_ex_is_branch <= w_is_branch;
          r_ex_rs1_val   <= w_rs1_val;
          r_ex_rs2_val   <= w_rs2_val;
          r_ex_imm       <= w_imm;
        end else begin
          r_ex_valid     <= 1'b0;
          r_ex_class     <= 2'd0;
          r_ex_funct     <= 4'd0;
          r_ex_rd        <= '0;
          r_ex_we        <= 1'b0;
          r_ex_is_load   <= 1'b0;
          r_ex_is_store  <= 1'b0;
          r_ex_is_branch <= 1'b0;
          r_ex_rs1_val   <= '0;
          r_ex_rs2_val   <= '0;
          r_ex_imm       <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.fetch_hold   = w_fetch_hold;
  assign bus.rs1_addr     = w_rs1_addr;
  assign bus.rs2_addr     = w_rs2_addr;
  assign bus.ex_valid     = r_ex_valid;
  assign bus.ex_class     = r_ex_class;
  assign bus.ex_funct     = r_ex_funct;
  assign bus.ex_rd        = r_ex_rd;
  assign bus.ex_we        = r_ex_we;
  assign bus.ex_is_load   = r_ex_is_load;
  assign bus.ex_is_store  = r_ex_is_store;
  assign bus.ex_is_branch = r_ex_is_branch;
  assign bus.ex_rs1_val   = r_ex_rs1_val;
  assign bus.ex_rs2_val   = r_ex_rs2_val;
  assign bus.ex_imm       = r_ex_imm;
  assign bus.illegal_insn = r_illegal;
  assign bus.halted       = (r_state == c_st_halted);

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : Directed self-checking bench for decode_stage. A small
//             regfile model answers the read ports; every expected value
//             is hand-derived from the instruction encoding.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decode_stage;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [15:0] regs [8];

  decode_stage_if #(.DATA_W(16), .REG_AW(3)) bus ();

  decode_stage #(.DATA_W(16), .REG_AW(3), .HALT_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Regfile model: same-cycle read; r0 holds junk so forcing is visible
  assign bus.rs1_data = regs[bus.rs1_addr];
  assign bus.rs2_data = regs[bus.rs2_addr];

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Directed sequence
  initial begin
    errors = 0;
    checks = 0;
    regs[0] = 16'hDEAD; regs[1] = 16'h0011; regs[2] = 16'h0005; regs[3] = 16'h0009;
    regs[4] = 16'h0044; regs[5] = 16'h0055; regs[6] = 16'h0066; regs[7] = 16'h0077;
    rst = 1'b1;
    bus.insn = 16'h0BA6;
    bus.branch_flag = 1'b0;
    bus.ex_stall = 1'b0;
    tick(); tick();

    // Reset state with a valid insn presented
    check("rst_valid",   bus.ex_valid, 0);
    check("rst_rd",      bus.ex_rd, 0);
    check("rst_rs1val",  bus.ex_rs1_val, 0);
    check("rst_halted",  bus.halted, 0);
    check("rst_illegal", bus.illegal_insn, 0);
    rst = 1'b0;

    // ALU ADD r7 = r2 + r3
    bus.insn = 16'h0BA6;
    #1;
    check("add_rs1addr", bus.rs1_addr, 2);
    check("add_rs2addr", bus.rs2_addr, 3);
    tick();
    check("add_valid",  bus.ex_valid, 1);
    check("add_class",  bus.ex_class, 0);
    check("add_funct",  bus.ex_funct, 2);
    check("add_rd",     bus.ex_rd, 7);
    check("add_we",     bus.ex_we, 1);
    check("add_rs1val", bus.ex_rs1_val, 16'h0005);
    check("add_rs2val", bus.ex_rs2_val, 16'h0009);

    // LI r5 = sext(0x1FF)
    bus.insn = 16'h8BFF;
    tick();
    check("li_imm",   bus.ex_imm, 16'hFFFF);
    check("li_we",    bus.ex_we, 1);
    check("li_rd",    bus.ex_rd, 5);
    check("li_class", bus.ex_class, 2);

    // ADD r1 = r0 + r0: r0 forced to zero
    bus.insn = 16'h0880;
    tick();
    check("r0_rs1val", bus.ex_rs1_val, 0);
    check("r0_rs2val", bus.ex_rs2_val, 0);

    // Branch-and-link, rs1 = r2, imm9 = -256
    bus.insn = 16'h7500;
    tick();
    check("bl_branch", bus.ex_is_branch, 1);
    check("bl_funct",  bus.ex_funct, 3);
    check("bl_rd",     bus.ex_rd, 7);
    check("bl_we",     bus.ex_we, 1);
    check("bl_imm",    bus.ex_imm, 16'hFF00);
    check("bl_rs1val", bus.ex_rs1_val, 16'h0005);

    // ST [r1 - 1] = r3
    bus.insn = 16'hA67F;
    tick();
    check("st_store",  bus.ex_is_store, 1);
    check("st_we",     bus.ex_we, 0);
    check("st_rs1val", bus.ex_rs1_val, 16'h0011);
    check("st_rs2val", bus.ex_rs2_val, 16'h0009);
    check("st_imm",    bus.ex_imm, 16'hFFFF);

    // LD r3 = [r1 + 2] followed by ADD r4 = r3 + r2 -> one bubble
    bus.insn = 16'h9642;
    tick();
    check("ld_load", bus.ex_is_load, 1);
    check("ld_rd",   bus.ex_rd, 3);
    check("ld_imm",  bus.ex_imm, 16'h0002);
    bus.insn = 16'h0A34;
    #1;
    check("lu_hold", bus.fetch_hold, 1);
    tick();
    check("lu_bubble",  bus.ex_valid, 0);
    check("lu_haz_hold", bus.fetch_hold, 0);
    check("lu_rs1addr", bus.rs1_addr, 3);
    tick();
    check("lu_issue",  bus.ex_valid, 1);
    check("lu_rd",     bus.ex_rd, 4);
    check("lu_rs1val", bus.ex_rs1_val, 16'h0009);

    // Hazard through rs2: LD r3, then ADD r4 = r2 + r3
    bus.insn = 16'h9642;
    tick();
    bus.insn = 16'h0A26;
    #1;
    check("lu2_hold", bus.fetch_hold, 1);
    tick();
    check("lu2_bubble", bus.ex_valid, 0);
    tick();
    check("lu2_rs2val", bus.ex_rs2_val, 16'h0009);

    // ALU write to r3 then read of r3 -> no interlock
    bus.insn = 16'h0994;
    tick();
    bus.insn = 16'h0A34;
    #1;
    check("alu_nohold", bus.fetch_hold, 0);
    tick();
    check("alu_issue", bus.ex_valid, 1);

    // Branch flush of a valid ALU insn
    bus.insn = 16'h0BA6;
    bus.branch_flag = 1'b1;
    #1;
    check("fl_hold", bus.fetch_hold, 0);
    tick();
    check("fl_bubble", bus.ex_valid, 0);
    bus.branch_flag = 1'b0;

    // Branch during HAZ drops the held insn
    bus.insn = 16'h9642;
    tick();
    bus.insn = 16'h0A34;
    tick();
    check("flh_bubble1", bus.ex_valid, 0);
    bus.branch_flag = 1'b1;
    tick();
    check("flh_bubble2", bus.ex_valid, 0);
    bus.branch_flag = 1'b0;
    bus.insn = 16'h0BA6;
    tick();
    check("flh_next_rd", bus.ex_rd, 7);

    // ex_stall held 3 cycles with changing insn
    bus.ex_stall = 1'b1;
    bus.insn = 16'h0994;
    #1;
    check("stl_hold0", bus.fetch_hold, 1);
    tick();
    check("stl_rd0", bus.ex_rd, 7);
    bus.insn = 16'h0A34;
    #1;
    check("stl_hold1", bus.fetch_hold, 1);
    tick();
    check("stl_rs1val1", bus.ex_rs1_val, 16'h0005);
    bus.insn = 16'h8BFF;
    #1;
    check("stl_hold2", bus.fetch_hold, 1);
    tick();
    check("stl_valid2", bus.ex_valid, 1);
    check("stl_rd2",    bus.ex_rd, 7);
    bus.ex_stall = 1'b0;
    bus.insn = 16'h0994;
    #1;
    check("stl_release", bus.fetch_hold, 0);
    tick();
    check("stl_issue_rd", bus.ex_rd, 3);
    check("stl_issue_v",  bus.ex_rs1_val, 16'h0011);

    // Stall and branch together: stall wins, then flush
    bus.ex_stall = 1'b1;
    bus.branch_flag = 1'b1;
    bus.insn = 16'h0BA6;
    #1;
    check("sb_hold", bus.fetch_hold, 1);
    tick();
    check("sb_keep", bus.ex_rd, 3);
    bus.ex_stall = 1'b0;
    tick();
    check("sb_flush", bus.ex_valid, 0);
    bus.branch_flag = 1'b0;

    // HALT, then an ALU insn and a branch are ignored
    bus.insn = 16'hC000;
    tick();
    check("h_halted", bus.halted, 1);
    check("h_bubble", bus.ex_valid, 0);
    bus.insn = 16'h0BA6;
    #1;
    check("h_hold", bus.fetch_hold, 1);
    tick();
    check("h_valid", bus.ex_valid, 0);
    bus.branch_flag = 1'b1;
    tick();
    check("h_sticky", bus.halted, 1);
    check("h_brhold", bus.fetch_hold, 1);
    bus.branch_flag = 1'b0;
    rst = 1'b1;
    tick();
    check("h_rst", bus.halted, 0);
    rst = 1'b0;
    tick();
    check("h_recover", bus.ex_valid, 1);

    // Illegal opcodes, fresh run
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.insn = 16'hC001;
    tick();
    check("ill_pulse", bus.illegal_insn, 1);
    check("ill_valid", bus.ex_valid, 0);
    check("ill_nohalt", bus.halted, 0);
    bus.insn = 16'h0BA6;
    tick();
    check("ill_clear", bus.illegal_insn, 0);
    check("ill_next",  bus.ex_valid, 1);
    bus.insn = 16'hB000;
    tick();
    check("ill_sub11", bus.illegal_insn, 1);
    bus.insn = 16'h0000;
    tick();
    check("nop_valid", bus.ex_valid, 0);
    check("nop_ill",   bus.illegal_insn, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
